// File: rtl/system_pkg.sv
// system_pkg: shared AHB-lite encodings and LSU master state type
package system_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, NONSEQ = 2'b10} htrans_e;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_LERR} lsu_mst_state_e;
endpackage

// File: rtl/ahblite_interconnection.sv
// ahblite_interconnection: AHB-lite bus signals between one master and the interconnect
interface ahblite_interconnection #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] haddr;
  logic [1:0] htrans;
  logic hwrite;
  logic [2:0] hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic hready;
  logic hresp;
  modport ahblite_master(output haddr, htrans, hwrite, hsize, hwdata, input hready, hresp, hrdata);
  modport ahblite_slave(input haddr, htrans, hwrite, hsize, hwdata, output hready, hresp, hrdata);
endinterface

// File: rtl/ahbl_be_decode.sv
// ahbl_be_decode: byte enables to hsize, low address offset and legality
module ahbl_be_decode
  import system_pkg::*;
(
  input  logic [3:0] be_i,
  output logic [2:0] hsize_o,
  output logic [1:0] off_o,
  output logic       legal_o
);
  always_comb begin
    hsize_o = HSIZE_WORD;
    off_o = 2'b00;
    legal_o = 1'b1;
    case (be_i)
      4'b1111: ;
      4'b0011: hsize_o = HSIZE_HALF;
      4'b1100: begin hsize_o = HSIZE_HALF; off_o = 2'b10; end
      4'b0001: hsize_o = HSIZE_BYTE;
      4'b0010: begin hsize_o = HSIZE_BYTE; off_o = 2'b01; end
      4'b0100: begin hsize_o = HSIZE_BYTE; off_o = 2'b10; end
      4'b1000: begin hsize_o = HSIZE_BYTE; off_o = 2'b11; end
      default: legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/ahbl_lsu_master.sv
// ahbl_lsu_master: LSU req/gnt/rvalid to pipelined AHB-lite master (AHBL_LSU_PERF_CNT_EN adds perf counters)
module ahbl_lsu_master
  import system_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o,
`ifdef AHBL_LSU_PERF_CNT_EN
  output logic [31:0]       perf_xfer_cnt_o,
  output logic [31:0]       perf_wait_cnt_o,
`endif
  ahblite_interconnection.ahblite_master master0
);
  lsu_mst_state_e state_q, state_d, nxt;
  logic we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0] hsize;
  logic [1:0] off;
  logic legal, a_vld, bus_free, gnt_bus, gnt_lerr, done, in_dphase;
  logic unused_addr;
  assign unused_addr = ^data_addr_i[1:0];
  ahbl_be_decode u_dec (.be_i(data_be_i), .hsize_o(hsize), .off_o(off), .legal_o(legal));
  always_comb begin
    in_dphase = state_q == ST_DATA || state_q == ST_ERR1;
    bus_free = state_q == ST_IDLE || (state_q == ST_DATA && master0.hready && !master0.hresp);
    a_vld = data_req_i && legal && (state_q == ST_IDLE || state_q == ST_DATA);
    gnt_bus = data_req_i && legal && master0.hready && bus_free;
    gnt_lerr = data_req_i && !legal && bus_free;
    done = in_dphase && master0.hready;
    nxt = gnt_bus ? ST_DATA : gnt_lerr ? ST_LERR : ST_IDLE;
    state_d = (in_dphase && !master0.hready)
            ? ((state_q == ST_ERR1 || master0.hresp) ? ST_ERR1 : ST_DATA) : nxt;
    we_d = gnt_bus ? data_we_i : we_q;
    wdata_d = gnt_bus ? data_wdata_i : wdata_q;
  end
  assign master0.htrans = gnt_bus ? NONSEQ : IDLE;
  assign master0.haddr = a_vld ? {data_addr_i[ADDR_W-1:2], off} : '0;
  assign master0.hwrite = a_vld && data_we_i;
  assign master0.hsize = a_vld ? hsize : HSIZE_WORD;
  assign master0.hwdata = wdata_q;
  assign data_gnt_o = gnt_bus || gnt_lerr;
  assign data_rvalid_o = done || state_q == ST_LERR;
  assign data_err_o = (done && (master0.hresp || state_q == ST_ERR1)) || state_q == ST_LERR;
  assign data_rdata_o = (state_q == ST_DATA && master0.hready && !master0.hresp && !we_q)
                      ? master0.hrdata : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
    end
  end
`ifdef AHBL_LSU_PERF_CNT_EN
  logic [31:0] xfer_q, wait_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_q <= '0;
      wait_q <= '0;
    end else begin
      xfer_q <= xfer_q + {31'b0, done};
      wait_q <= wait_q + {31'b0, in_dphase && !master0.hready};
    end
  end
  assign perf_xfer_cnt_o = xfer_q;
  assign perf_wait_cnt_o = wait_q;
`endif
endmodule

// File: tb/tb_ahbl_lsu_master.sv
// tb_ahbl_lsu_master: directed and random transfers checked against a transaction-level model
module tb_ahbl_lsu_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic req, we, gnt, rvalid, err;
  logic [3:0] be;
  logic [31:0] addr, wdata, rdata;
`ifdef AHBL_LSU_PERF_CNT_EN
  logic [31:0] pxfer, pwait;
`endif
  ahblite_interconnection bus ();
  ahbl_lsu_master dut (
    .clk(clk), .rst(rst), .data_req_i(req), .data_gnt_o(gnt), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid),
    .data_rdata_o(rdata), .data_err_o(err),
`ifdef AHBL_LSU_PERF_CNT_EN
    .perf_xfer_cnt_o(pxfer), .perf_wait_cnt_o(pwait),
`endif
    .master0(bus)
  );
  typedef struct {
    bit we; bit [3:0] be; bit [31:0] addr; bit [31:0] wdata; bit [31:0] rdata; int waits; bit err;
  } tx_t;
  typedef struct { bit err; bit [31:0] rdata; } rsp_t;
  tx_t txq[$];
  rsp_t sbq[$];
  tx_t cur;
  bit act, lerr_p, pres, stg, gap_en;
  int wl, exp_xfer, exp_wait;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Legal enables are a naturally aligned run of 1, 2 or 4 lanes.
  function automatic void ref_dec(input bit [3:0] b, output bit lg, output bit [2:0] sz, output bit [1:0] of);
    int n = $countones(b);
    int o = 0;
    for (int i = 3; i >= 0; i--) if (b[i]) o = i;
    lg = (n == 1 || n == 2 || n == 4) && ((((1 << n) - 1) << o) == int'(b)) && (o % n == 0);
    sz = n == 4 ? 3'd2 : n == 2 ? 3'd1 : 3'd0;
    of = 2'(o);
  endfunction

  task automatic add(input bit w, input bit [3:0] b, input bit [31:0] a, input bit [31:0] wd,
                     input bit [31:0] rd, input int ws, input bit e);
    tx_t t;
    t.we = w; t.be = b; t.addr = a; t.wdata = wd; t.rdata = rd; t.waits = ws; t.err = e;
    txq.push_back(t);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'hf; addr = '0; wdata = '0;
    bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
    act = 0; lerr_p = 0; pres = 0; stg = 0; wl = 0; exp_xfer = 0; exp_wait = 0;
    txq.delete(); sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input int budget);
    int cyc = 0;
    bit hr, hp, lg, egnt, erv;
    bit [2:0] sz;
    bit [1:0] of;
    rsp_t r;
    while ((txq.size() != 0 || act || lerr_p) && cyc < budget) begin
      @(posedge clk); #1; cyc++;
      if (!pres && txq.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) pres = 1;
      req = pres;
      if (pres) begin
        we = txq[0].we; be = txq[0].be; addr = txq[0].addr; wdata = txq[0].wdata;
      end else begin
        we = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
      end
      hr = !act || (wl == 0 && (!cur.err || stg));
      hp = act && wl == 0 && cur.err;
      bus.hready = hr; bus.hresp = hp;
      bus.hrdata = (act && hr && !hp) ? cur.rdata : $urandom;
      #3;
      lg = 0; sz = 0; of = 0;
      if (pres) ref_dec(txq[0].be, lg, sz, of);
      egnt = pres && !lerr_p && (!act || (hr && !hp));
      erv = lerr_p || (act && hr);
      chk("gnt", 32'(gnt), 32'(egnt));
      chk("htrans", 32'(bus.htrans), (egnt && lg) ? 32'h2 : 32'h0);
      chk("rvalid", 32'(rvalid), 32'(erv));
      if (egnt && lg) begin
        chk("haddr", bus.haddr, {addr[31:2], of});
        chk("hsize", 32'(bus.hsize), 32'(sz));
        chk("hwrite", 32'(bus.hwrite), 32'(we));
      end
      if (act && cur.we) chk("hwdata", bus.hwdata, cur.wdata);
      if (erv) begin
        r = sbq.pop_front();
        chk("err", 32'(err), 32'(r.err));
        chk("rdata", rdata, r.rdata);
      end
      exp_xfer += int'(act && hr);
      exp_wait += int'(act && !hr);
      if (act) begin
        if (wl > 0) wl--;
        else if (cur.err && !stg) stg = 1;
        else act = 0;
      end
      lerr_p = 0;
      if (egnt) begin
        tx_t t = txq.pop_front();
        pres = 0;
        r.err = !lg || t.err;
        r.rdata = (lg && !t.we && !t.err) ? t.rdata : 32'h0;
        sbq.push_back(r);
        if (lg) begin act = 1; cur = t; wl = t.waits; stg = 0; end
        else lerr_p = 1;
      end
    end
    req = 1'b0;
    chk("pending", 32'(txq.size() + int'(act) + int'(lerr_p)), 32'h0);
`ifdef AHBL_LSU_PERF_CNT_EN
    @(posedge clk); #1;
    chk("perf_xfer", pxfer, 32'(exp_xfer));
    chk("perf_wait", pwait, 32'(exp_wait));
`endif
  endtask

  initial begin
    bit [3:0] lb [7] = '{4'hf, 4'h3, 4'hc, 4'h1, 4'h2, 4'h4, 4'h8};
    apply_reset();
    rst = 1'b1; #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_htrans", 32'(bus.htrans), 32'h0);
    chk("rst_hwrite", 32'(bus.hwrite), 32'h0);
    chk("rst_hsize", 32'(bus.hsize), 32'h2);
    chk("rst_haddr", bus.haddr, 32'h0);
    chk("rst_hwdata", bus.hwdata, 32'h0);
    apply_reset();
    gap_en = 0;
    add(1, 4'hf, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    run(50);
    add(0, 4'h4, 32'h204, 32'h12345678, 32'h00AB0000, 0, 0);
    run(50);
    apply_reset();
    add(0, 4'hf, 32'h0, 32'h0, 32'h11111111, 0, 0);
    add(0, 4'hf, 32'h4, 32'h0, 32'h22222222, 2, 0);
    add(0, 4'hf, 32'h8, 32'h0, 32'h33333333, 0, 0);
    run(50);
    add(1, 4'hf, 32'h300, 32'hCAFEF00D, 32'h0, 0, 1);
    add(0, 4'hf, 32'h304, 32'h0, 32'h44444444, 0, 0);
    run(50);
    add(0, 4'h5, 32'h400, 32'h0, 32'h55555555, 0, 0);
    add(1, 4'h3, 32'h402, 32'hA5A5A5A5, 32'h0, 1, 0);
    run(50);
    apply_reset();
    gap_en = 1;
    for (int i = 0; i < 300; i++)
      add(1'($urandom), ($urandom_range(0, 7) == 0) ? 4'($urandom) : lb[$urandom_range(0, 6)],
          $urandom, $urandom, $urandom,
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0, $urandom_range(0, 7) == 0);
    run(5000);
    apply_reset();
    @(posedge clk); #1;
    req = 1; we = 0; be = 4'hf; addr = 32'h40; bus.hready = 1; bus.hresp = 0;
    #3 chk("mid_gnt", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    req = 0; bus.hready = 0; bus.hrdata = 32'h99999999;
    #3 chk("mid_wait_rvalid", 32'(rvalid), 32'h0);
    rst = 1'b1; bus.hready = 1; #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    chk("mid_rst_htrans", 32'(bus.htrans), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #4;
      chk("post_rst_rvalid", 32'(rvalid), 32'h0);
    end
`ifdef AHBL_LSU_PERF_CNT_EN
    chk("post_rst_xfer", pxfer, 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
